fifo_word_unpacker: RTL and testbench
=====================================

# fifo_word_unpacker

Downstream consumer of the 32-bit × 8-deep FIFO. It pops one 32-bit word at a time through the FIFO's read port, which has one cycle of registered read latency. It then emits the word as four 8-bit beats on a valid/ready byte stream, marking the last beat of each word. It sits between the FIFO and byte-wide sinks (UART TX, SPI shifter).

## Interface
Parameters:
- `CNT_W`, default 16: width of the completed-word counter.

Ports:
- `clk`, input, 1: the single clock; every register updates on its rising edge.
- `rst`, input, 1: reset, synchronous, active-low. It is sampled on the rising edge of `clk`.
- `fifo_empty`, input, 1: the FIFO's empty flag.
- `fifo_data`, input, 32: the FIFO's `data_out`. It is valid in the cycle after a cycle in which `fifo_rd_en` was high and `fifo_empty` was low.
- `fifo_rd_en`, output, 1: FIFO pop request, combinational.
- `m_data`, output, 8: byte-stream data.
- `m_valid`, output, 1: byte-stream valid.
- `m_ready`, input, 1: byte-stream ready from the sink.
- `m_last`, output, 1: high on the 4th beat of each word.
- `busy`, output, 1: high in FETCH and SEND.
- `word_cnt`, output, CNT_W: count of fully transmitted words. Wraps modulo 2^CNT_W.

## Operation
- The state machine has three states: IDLE, FETCH and SEND. There is a 2-bit beat index `idx` and a 32-bit holding register `hold`.
- Pop request: `fifo_rd_en` = `!fifo_empty` && (`state==IDLE` || (`state==SEND` && `idx==3` && `m_ready`)).
- IDLE:
  - If `fifo_rd_en` is high, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - Lasts exactly one cycle.
  - On the closing edge, `hold <= fifo_data` and `idx <= 0`, then go to SEND.
- SEND:
  - `m_valid` is high.
  - `m_data` = byte `idx` of `hold`; byte order is set under Configuration.
  - `m_last` = (`idx==3`).
  - On a handshake (`m_valid && m_ready`) with `idx<3`: `idx <= idx+1`.
  - On a handshake with `idx==3`:
    - `word_cnt <= word_cnt+1`.
    - If `fifo_rd_en` is high, go to FETCH (back-to-back words).
    - Otherwise go to IDLE.
- Without a handshake, all outputs hold steady. `m_data` and `m_last` must not change while `m_valid` is high and `m_ready` is low.
- `fifo_rd_en` is never asserted while `fifo_empty` is high. At most one pop is outstanding at a time.
- Reset (`rst==0` at an edge):
  - state returns to IDLE, `idx` = 0, `hold` = 0, `word_cnt` = 0.
  - A partially sent word is discarded.
  - `fifo_rd_en` is forced low while `rst` is low.
- Reset values of outputs: `m_valid`=0, `m_data`=0x00, `m_last`=0, `busy`=0, `word_cnt`=0, `fifo_rd_en`=0.

## Timing
- First-byte latency: pop in cycle N (IDLE, not empty) → FETCH in N+1 → `m_valid` high in N+2.
- Best-case throughput with `m_ready` tied high and the FIFO never empty: 4 bytes per 5 cycles, since every word spends one cycle in FETCH.
- `m_data`, `m_valid`, `m_last` and `busy` are decoded from registered state and registered `hold`/`idx`, so there is no combinational path from `m_ready` to them.
- `fifo_rd_en` does depend combinationally on `m_ready` and `fifo_empty`.
- `word_cnt` increments on the edge that accepts beat 3. At 2^CNT_W−1 it wraps to 0.

## Configuration
- Macro `UNPACK_MSB_FIRST_EN`:
  - Defined: beat 0 = `hold[31:24]`, beat 3 = `hold[7:0]`.
  - Undefined (default): beat 0 = `hold[7:0]`, beat 3 = `hold[31:24]`.
- Control flow and timing are identical in both builds.

## Test plan
- Single word, `m_ready`=1, word 0x11223344 pushed, LSB-first build:
  - `m_data` sequence is 0x44, 0x33, 0x22, 0x11.
  - `m_last` is high only on 0x11.
  - `word_cnt`=1.
  - First `m_valid` appears 2 cycles after `fifo_rd_en`.
- Same stimulus with `UNPACK_MSB_FIRST_EN` defined: sequence is 0x11, 0x22, 0x33, 0x44.
- Backpressure: hold `m_ready` low for 3 cycles on beat 1 of 0xA5B6C7D8. `m_data`=0xC7 is held stable throughout, no extra beats appear, and exactly one `fifo_rd_en` pulse occurs per word.
- Three words queued, `m_ready`=1:
  - `fifo_rd_en` pulses in the same cycle as each beat-3 handshake.
  - 12 beats are emitted in 15 cycles from the first `m_valid`.
  - `word_cnt`=3.
  - The FIFO is never popped while empty.
- Reset mid-word: drive `rst` low after beat 1 of 0xDEADBEEF. The next edge gives `m_valid`=0 and `word_cnt`=0. After release with the FIFO empty, the block stays in IDLE with `busy`=0.
- Counter wrap with CNT_W=2: send 5 words; `word_cnt` reads 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/fifo_word_unpacker.sv
// rtl/fifo_word_unpacker.sv - pops 32-bit FIFO words and streams them as four byte beats (option: UNPACK_MSB_FIRST_EN)
module fifo_word_unpacker #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [31:0]      fifo_data,
    output logic             fifo_rd_en,
    output logic [7:0]       m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             busy,
    output logic [CNT_W-1:0] word_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [31:0]        hold_q, hold_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               sending;
    logic               handshake;
    logic               last_beat;
    logic [1:0]         byte_sel;

    assign sending   = (state_q == ST_SEND);
    assign handshake = sending && m_ready;
    assign last_beat = (idx_q == 2'd3);

    // Pop request: only one pop in flight, issued from IDLE or on the edge that retires beat 3
    always_comb begin
        fifo_rd_en = rst && !fifo_empty &&
                     ((state_q == ST_IDLE) || (sending && last_beat && m_ready));
    end

    // Byte lane selected by the beat index; the build option reverses the lane order
    always_comb begin
`ifdef UNPACK_MSB_FIRST_EN
        byte_sel = 2'd3 - idx_q;
`else
        byte_sel = idx_q;
`endif
    end

    // Stream outputs decode only registered state, so m_ready never reaches them combinationally
    always_comb begin
        m_valid  = sending;
        m_last   = sending && last_beat;
        busy     = (state_q == ST_FETCH) || sending;
        word_cnt = cnt_q;
        m_data   = 8'h00;
        if (sending) begin
            case (byte_sel)
                2'd0:    m_data = hold_q[7:0];
                2'd1:    m_data = hold_q[15:8];
                2'd2:    m_data = hold_q[23:16];
                default: m_data = hold_q[31:24];
            endcase
        end
    end

    // Next-state logic: IDLE waits for a pop, FETCH captures the read data, SEND walks four beats
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (fifo_rd_en) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                hold_d  = fifo_data;
                idx_d   = 2'd0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (handshake) begin
                    if (last_beat) begin
                        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        state_d = fifo_rd_en ? ST_FETCH : ST_IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset discards any partially sent word
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            hold_q  <= 32'h0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// tb/tb_fifo_word_unpacker.sv - randomized self-checking bench for fifo_word_unpacker
module tb_fifo_word_unpacker;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_ready;
    logic [31:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_last;
    logic        busy;
    logic [15:0] word_cnt;

    logic        s_rd_en;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_busy;
    logic [1:0]  s_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    fifo_word_unpacker #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(fifo_rd_en), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .busy(busy), .word_cnt(word_cnt)
    );

    fifo_word_unpacker #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(s_rd_en), .m_data(s_data), .m_valid(s_valid),
        .m_ready(m_ready), .m_last(s_last), .busy(s_busy), .word_cnt(s_cnt)
    );

    // FIFO stand-in: pushes from tasks, pops registered with one cycle of read latency
    logic [31:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en && !fifo_empty) begin
            fifo_data <= mem[rd_ptr % 64];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Stream monitor: records accepted beats, pop cycles and protocol violations
    logic [7:0] rx_data[$];
    logic       rx_last[$];
    int         rx_cyc[$];
    int         pop_cyc[$];
    int         empty_err = 0;
    int         stab_err  = 0;
    logic       stall = 1'b0;
    logic [7:0] stall_data;
    logic       stall_last;

    always @(negedge clk) begin
        if (rst) begin
            if (fifo_rd_en && fifo_empty) empty_err++;
            if (fifo_rd_en) pop_cyc.push_back(cyc);
            if (stall && (m_valid !== 1'b1 || m_data !== stall_data || m_last !== stall_last))
                stab_err++;
            if (m_valid && m_ready) begin
                rx_data.push_back(m_data);
                rx_last.push_back(m_last);
                rx_cyc.push_back(cyc);
            end
            stall      = m_valid && !m_ready;
            stall_data = m_data;
            stall_last = m_last;
        end else begin
            stall = 1'b0;
        end
    end

    // Reference: byte i of a word in emission order
    function automatic logic [7:0] exp_byte(input logic [31:0] w, input int i);
        logic [31:0] sh;
`ifdef UNPACK_MSB_FIRST_EN
        sh = w >> (8 * (3 - i));
`else
        sh = w >> (8 * i);
`endif
        return sh[7:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr % 64] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic clear_rx();
        rx_data.delete();
        rx_last.delete();
        rx_cyc.delete();
        pop_cyc.delete();
    endtask

    task automatic wait_rx(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (rx_data.size() < n && k < budget) begin
            step();
            k++;
        end
        if (rx_data.size() < n) begin
            total++; bad++;
            $display("FAIL %s timeout: beats=%0d required=%0d", name, rx_data.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        m_ready = 1'b0;
        push(32'h01020304);
        repeat (3) step();
        total++; if (m_valid !== 1'b0)   begin bad++; $display("FAIL rst_valid got=%b exp=0", m_valid); end
        total++; if (m_data !== 8'h00)   begin bad++; $display("FAIL rst_data got=%h exp=00", m_data); end
        total++; if (m_last !== 1'b0)    begin bad++; $display("FAIL rst_last got=%b exp=0", m_last); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (word_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", word_cnt); end
        total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL rst_rden got=%b exp=0", fifo_rd_en); end
        wr_ptr = rd_ptr;
        rst = 1'b1;
        step();
    endtask

    task automatic test_single();
        logic [31:0] w;
        logic [15:0] base;
        w = 32'h11223344;
        base = word_cnt;
        m_ready = 1'b1;
        clear_rx();
        push(w);
        wait_rx(4, 50, "single");
        step();
        for (int i = 0; i < 4 && i < rx_data.size(); i++) begin
            total++;
            if (rx_data[i] !== exp_byte(w, i) || rx_last[i] !== (i == 3)) begin
                bad++;
                $display("FAIL single_beat%0d got=%h/%b exp=%h/%b", i, rx_data[i], rx_last[i], exp_byte(w, i), (i == 3));
            end
        end
        total++;
        if (word_cnt !== 16'(base + 1)) begin bad++; $display("FAIL single_cnt got=%0d exp=%0d", word_cnt, 16'(base + 1)); end
        total++;
        if (pop_cyc.size() != 1 || rx_cyc.size() < 1 || rx_cyc[0] - pop_cyc[0] != 2) begin
            bad++;
            $display("FAIL single_latency pops=%0d first_valid_minus_pop=%0d exp=2", pop_cyc.size(),
                     (rx_cyc.size() > 0 && pop_cyc.size() > 0) ? rx_cyc[0] - pop_cyc[0] : -1);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w;
        w = 32'hA5B6C7D8;
        m_ready = 1'b1;
        clear_rx();
        push(w);
        wait_rx(1, 50, "bp_first");
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (m_valid !== 1'b1 || m_data !== exp_byte(w, 1) || m_last !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d got=%b/%h/%b exp=1/%h/0", i, m_valid, m_data, m_last, exp_byte(w, 1));
            end
            step();
        end
        m_ready = 1'b1;
        wait_rx(4, 50, "bp_rest");
        repeat (4) step();
        total++;
        if (rx_data.size() != 4) begin bad++; $display("FAIL bp_beats got=%0d exp=4", rx_data.size()); end
        for (int i = 0; i < 4 && i < rx_data.size(); i++) begin
            total++;
            if (rx_data[i] !== exp_byte(w, i)) begin
                bad++; $display("FAIL bp_beat%0d got=%h exp=%h", i, rx_data[i], exp_byte(w, i));
            end
        end
        total++;
        if (pop_cyc.size() != 1) begin bad++; $display("FAIL bp_pops got=%0d exp=1", pop_cyc.size()); end
        total++;
        if (stab_err != 0) begin bad++; $display("FAIL bp_stable errors=%0d exp=0", stab_err); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [3];
        logic [15:0] base;
        int off;
        base = word_cnt;
        m_ready = 1'b1;
        clear_rx();
        for (int i = 0; i < 3; i++) begin
            w[i] = $urandom;
            push(w[i]);
        end
        wait_rx(12, 100, "b2b");
        step();
        for (int i = 0; i < 12 && i < rx_data.size(); i++) begin
            off = (i / 4) * 5 + (i % 4);
            total++;
            if (rx_data[i] !== exp_byte(w[i / 4], i % 4) || rx_last[i] !== ((i % 4) == 3) ||
                rx_cyc[i] - rx_cyc[0] != off) begin
                bad++;
                $display("FAIL b2b_beat%0d got=%h/%b@%0d exp=%h/%b@%0d", i, rx_data[i], rx_last[i],
                         rx_cyc[i] - rx_cyc[0], exp_byte(w[i / 4], i % 4), ((i % 4) == 3), off);
            end
        end
        total++;
        if (pop_cyc.size() != 3 || rx_data.size() != 12 ||
            pop_cyc[1] != rx_cyc[3] || pop_cyc[2] != rx_cyc[7]) begin
            bad++;
            $display("FAIL b2b_pop_align pops=%0d exp=3 (pops 2,3 on beat-3 handshakes)", pop_cyc.size());
        end
        total++;
        if (word_cnt !== 16'(base + 3)) begin bad++; $display("FAIL b2b_cnt got=%0d exp=%0d", word_cnt, 16'(base + 3)); end
        total++;
        if (empty_err != 0) begin bad++; $display("FAIL b2b_empty_pop errors=%0d exp=0", empty_err); end
    endtask

    task automatic test_random();
        logic [31:0] w [$];
        logic [15:0] base;
        int n;
        int errs;
        base = word_cnt;
        clear_rx();
        n = 0;
        for (int c = 0; c < 300; c++) begin
            if (n < 12 && $urandom_range(0, 3) == 0) begin
                w.push_back($urandom);
                push(w[n]);
                n++;
            end
            m_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        m_ready = 1'b1;
        wait_rx(4 * n, 200, "rand");
        step();
        errs = 0;
        for (int i = 0; i < rx_data.size() && i < 4 * n; i++) begin
            if (rx_data[i] !== exp_byte(w[i / 4], i % 4) || rx_last[i] !== ((i % 4) == 3)) errs++;
        end
        total++;
        if (errs != 0 || rx_data.size() != 4 * n) begin
            bad++; $display("FAIL rand_stream beats=%0d exp=%0d wrong=%0d", rx_data.size(), 4 * n, errs);
        end
        total++;
        if (word_cnt !== 16'(base + n)) begin bad++; $display("FAIL rand_cnt got=%0d exp=%0d", word_cnt, 16'(base + n)); end
        total++;
        if (stab_err != 0 || empty_err != 0) begin
            bad++; $display("FAIL rand_protocol stable_err=%0d empty_pop=%0d exp=0/0", stab_err, empty_err);
        end
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b1;
        clear_rx();
        push(32'hDEADBEEF);
        wait_rx(2, 50, "rmid");
        rst = 1'b0;
        step();
        total++;
        if (m_valid !== 1'b0 || word_cnt !== 16'd0) begin
            bad++; $display("FAIL rmid_reset got valid=%b cnt=%0d exp=0/0", m_valid, word_cnt);
        end
        rst = 1'b1;
        repeat (4) step();
        total++;
        if (busy !== 1'b0 || m_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin
            bad++; $display("FAIL rmid_idle got busy=%b valid=%b rden=%b exp=0/0/0", busy, m_valid, fifo_rd_en);
        end
        total++;
        if (rx_data.size() != 2) begin bad++; $display("FAIL rmid_beats got=%0d exp=2", rx_data.size()); end
    endtask

    task automatic test_wrap();
        logic [1:0] exp_c;
        m_ready = 1'b1;
        clear_rx();
        for (int k = 0; k < 5; k++) begin
            push($urandom);
            wait_rx(4 * (k + 1), 50, "wrap");
            step();
            exp_c = 2'((k + 1) % 4);
            total++;
            if (s_cnt !== exp_c) begin bad++; $display("FAIL wrap_cnt%0d got=%0d exp=%0d", k, s_cnt, exp_c); end
        end
    endtask

    initial begin
        rst = 1'b0;
        m_ready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
